// File: rtl/alu_regfile_if.sv
// Signal bundle between a datapath controller and alu_regfile: register file
// write/read ports plus the independent combinational ALU operands and result.
interface alu_regfile_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  // Write qualification: a register write happens on the rising edge only when
  // WRITE=1 and BUSYWAIT=0; BUSYWAIT stalls the write and holds all contents.
  logic                  BUSYWAIT;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic [DATA_WIDTH-1:0] IN;
  logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
  logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
  logic [DATA_WIDTH-1:0] OUT1;
  logic [DATA_WIDTH-1:0] OUT2;
  logic [DATA_WIDTH-1:0] DATA1;
  logic [DATA_WIDTH-1:0] DATA2;
  logic [2:0]            SELECT;
  logic [DATA_WIDTH-1:0] RESULT;
  logic                  ZERO;

  modport master (
    output BUSYWAIT, WRITE, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS,
    output DATA1, DATA2, SELECT,
    input  OUT1, OUT2, RESULT, ZERO
  );

  modport slave (
    input  BUSYWAIT, WRITE, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS,
    input  DATA1, DATA2, SELECT,
    output OUT1, OUT2, RESULT, ZERO
  );
endinterface

// File: rtl/alu_regfile.sv
// Eight-entry register file with two combinational read ports, plus a
// separate combinational ALU (forward/add/and/or) sharing no internal path.
module alu_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  alu_regfile_if.slave  bus
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] result;

  always_comb begin
    regs_d = regs_q;
    if (bus.WRITE && !bus.BUSYWAIT) begin
      regs_d[bus.INADDRESS] = bus.IN;
    end
  end

  // Reset wins over any write presented on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from storage, so a same-cycle write is not bypassed.
  assign bus.OUT1 = regs_q[bus.OUT1ADDRESS];
  assign bus.OUT2 = regs_q[bus.OUT2ADDRESS];

  always_comb begin
    result = '0;
    case (bus.SELECT)
      3'b000:  result = bus.DATA2;
      3'b001:  result = bus.DATA1 + bus.DATA2;
      3'b010:  result = bus.DATA1 & bus.DATA2;
      3'b011:  result = bus.DATA1 | bus.DATA2;
      default: result = '0;
    endcase
  end

  assign bus.RESULT = result;
  assign bus.ZERO   = (result == '0);
endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile: register reset/write/stall behaviour and
// ALU operations, checked through an expected-value queue.
module tb_alu_regfile;
  logic CLK = 1'b0;
  logic RESET;

  alu_regfile_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  alu_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: got %h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic read_pair(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                           input logic [7:0] e1, input logic [7:0] e2);
    bus.OUT1ADDRESS = a1;
    bus.OUT2ADDRESS = a2;
    push_exp(e1);
    push_exp(e2);
    #1;
    check({tag, "_out1"}, bus.OUT1);
    check({tag, "_out2"}, bus.OUT2);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus.WRITE     = 1'b1;
    bus.INADDRESS = a;
    bus.IN        = d;
    @(posedge CLK);
    #1;
    bus.WRITE = 1'b0;
  endtask

  task automatic alu_op(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [2:0] sel, input logic [7:0] eres, input logic ezero);
    bus.DATA1  = d1;
    bus.DATA2  = d2;
    bus.SELECT = sel;
    push_exp(eres);
    push_exp({7'b0, ezero});
    #1;
    check({tag, "_result"}, bus.RESULT);
    check({tag, "_zero"}, {7'b0, bus.ZERO});
  endtask

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] s);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (s == 3'd0) return b;
    if (s == 3'd1) return sum[7:0];
    if (s == 3'd2) return a & b;
    if (s == 3'd3) return a | b;
    return 8'h00;
  endfunction

  initial begin
    logic [7:0] ra, rb, rr;
    logic [2:0] rs;
    logic [7:0] model_regs [8];

    RESET           = 1'b1;
    bus.BUSYWAIT    = 1'b0;
    bus.WRITE       = 1'b0;
    bus.INADDRESS   = '0;
    bus.IN          = '0;
    bus.OUT1ADDRESS = '0;
    bus.OUT2ADDRESS = '0;
    bus.DATA1       = '0;
    bus.DATA2       = '0;
    bus.SELECT      = '0;

    // One reset edge, then every address on both ports reads zero.
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_pair("reset_sweep", 3'(i), 3'(7 - i), 8'h00, 8'h00);
    end

    write_reg(3'd2, 8'h05);
    write_reg(3'd4, 8'hF0);
    read_pair("write_2_4", 3'd2, 3'd4, 8'h05, 8'hF0);
    read_pair("same_addr", 3'd4, 3'd4, 8'hF0, 8'hF0);

    // WRITE=0 leaves contents untouched.
    @(negedge CLK);
    bus.INADDRESS = 3'd4;
    bus.IN        = 8'h11;
    @(posedge CLK);
    #1;
    read_pair("no_write", 3'd4, 3'd2, 8'hF0, 8'h05);

    // Stalled write held for three edges.
    @(negedge CLK);
    bus.BUSYWAIT  = 1'b1;
    bus.WRITE     = 1'b1;
    bus.INADDRESS = 3'd2;
    bus.IN        = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      read_pair("busywait_hold", 3'd2, 3'd4, 8'h05, 8'hF0);
    end
    @(negedge CLK);
    bus.BUSYWAIT = 1'b0;
    read_pair("pre_edge_old", 3'd2, 3'd2, 8'h05, 8'h05);
    @(posedge CLK);
    #1;
    bus.WRITE = 1'b0;
    read_pair("stall_release", 3'd2, 3'd4, 8'hAA, 8'hF0);

    // Reset alongside a write, with ALU operands live: reset wins, ALU unaffected.
    @(negedge CLK);
    RESET         = 1'b1;
    bus.WRITE     = 1'b1;
    bus.INADDRESS = 3'd3;
    bus.IN        = 8'h77;
    @(posedge CLK);
    #1;
    alu_op("alu_during_reset", 8'h12, 8'h34, 3'd1, 8'h46, 1'b0);
    RESET     = 1'b0;
    bus.WRITE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_pair("reset_write_sweep", 3'(i), 3'd3, 8'h00, 8'h00);
    end

    alu_op("add_sub5", 8'h05, 8'hFB, 3'd1, 8'h00, 1'b1);
    alu_op("add_wrap", 8'hFF, 8'h02, 3'd1, 8'h01, 1'b0);
    alu_op("and", 8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0);
    alu_op("or", 8'hF0, 8'h3C, 3'd3, 8'hFC, 1'b0);
    alu_op("fwd", 8'hF0, 8'h3C, 3'd0, 8'h3C, 1'b0);
    alu_op("rsvd7", 8'hF0, 8'h3C, 3'd7, 8'h00, 1'b1);
    alu_op("rsvd4", 8'hFF, 8'hFF, 3'd4, 8'h00, 1'b1);
    alu_op("fwd_zero", 8'hFF, 8'h00, 3'd0, 8'h00, 1'b1);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 3'($urandom_range(0, 7));
      rr = alu_model(ra, rb, rs);
      alu_op("alu_rand", ra, rb, rs, rr, rr == 8'h00);
    end

    // Random writes tracked by a reference array, then read back.
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    for (int i = 0; i < 10; i++) begin
      rs = 3'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 255));
      write_reg(rs, ra);
      model_regs[rs] = ra;
    end
    for (int i = 0; i < 8; i++) begin
      read_pair("rand_regs", 3'(i), 3'((i + 1) % 8), model_regs[i], model_regs[(i + 1) % 8]);
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_regfile.md
ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: register and ALU operand width; all behaviour below is specified at 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3: register address width, giving 8 registers.
REQ-003 CLK  in  1  single clock; all state changes occur on the rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 BUSYWAIT  in  1  memory stall; when high, it blocks register writes.
REQ-006 WRITE  in  1  register write enable.
REQ-007 INADDRESS  in  3  write register index.
REQ-008 IN  in  8  write data.
REQ-009 OUT1ADDRESS  in  3  read port 1 register index.
REQ-010 OUT2ADDRESS  in  3  read port 2 register index.
REQ-011 OUT1  out  8  read port 1 data.
REQ-012 OUT2  out  8  read port 2 data.
REQ-013 DATA1  in  8  ALU operand 1.
REQ-014 DATA2  in  8  ALU operand 2.
REQ-015 SELECT  in  3  ALU operation code.
REQ-016 RESULT  out  8  ALU result.
REQ-017 ZERO  out  1  high when RESULT equals 0.

Function
REQ-018 The register file and ALU SHALL be independent datapaths inside the block; no internal connection exists between them.
REQ-019 Register storage SHALL be 8 registers of 8 bits each.
REQ-020 OUT1 and OUT2 SHALL be combinational reads of the registers addressed by OUT1ADDRESS and OUT2ADDRESS, with no clock latency.
REQ-021 Both read ports SHALL be able to address the same register simultaneously.
REQ-022 On a rising CLK edge with RESET=0, WRITE=1 and BUSYWAIT=0, register[INADDRESS] SHALL take the value of IN.
REQ-023 On a rising edge with WRITE=0 or BUSYWAIT=1, no register SHALL change.
REQ-024 When a read address equals INADDRESS during a write cycle, the read port SHALL show the old value before the edge and the new value after it; there is no write-through bypass.
REQ-025 ALU operation SHALL be purely combinational:
- SELECT=000 forward: RESULT = DATA2.
- SELECT=001 add: RESULT = (DATA1 + DATA2) mod 256; the carry is discarded.
- SELECT=010 and: RESULT = DATA1 & DATA2, bitwise.
- SELECT=011 or: RESULT = DATA1 | DATA2, bitwise.
- SELECT=100..111 reserved: RESULT = 8'h00.
REQ-026 Subtraction SHALL be performed by the caller presenting the two's complement of the subtrahend on DATA2 with SELECT=001; the ALU has no sub opcode.
REQ-027 ZERO SHALL be 1 exactly when RESULT == 8'h00, for every SELECT value including the reserved codes.
REQ-028 RESULT and ZERO SHALL update whenever DATA1, DATA2 or SELECT changes, independent of CLK, RESET and BUSYWAIT.

Reset
REQ-029 On a rising CLK edge with RESET=1, all 8 registers SHALL become 8'h00, regardless of WRITE and BUSYWAIT.
REQ-030 RESET SHALL take priority over a simultaneous write; the write is discarded.
REQ-031 After reset, OUT1 and OUT2 SHALL read 8'h00 for every address.
REQ-032 RESET SHALL have no effect on the ALU outputs.
REQ-033 Register contents before the first reset edge are undefined; the bench SHALL apply reset before checking any register value.

Verification
REQ-034 Apply RESET for 1 edge, then release; sweep OUT1ADDRESS and OUT2ADDRESS over 0..7 -> OUT1 = OUT2 = 8'h00 at every address.
REQ-035 Write IN=8'h05 to reg 2 and IN=8'hF0 to reg 4 with BUSYWAIT=0; set OUT1ADDRESS=2, OUT2ADDRESS=4 -> OUT1=8'h05, OUT2=8'hF0, both valid before the next edge.
REQ-036 Hold BUSYWAIT=1 with WRITE=1, INADDRESS=2, IN=8'hAA for 3 edges -> reg 2 stays 8'h05; drop BUSYWAIT -> reg 2 = 8'hAA after the next edge.
REQ-037 Assert RESET and WRITE=1 together, INADDRESS=3, IN=8'h77 -> reg 3 = 8'h00, and all other registers are 8'h00.
REQ-038 ALU operations, each with SELECT as given:
- DATA1=8'h05, DATA2=8'hFB (two's complement of 5), SELECT=001 -> RESULT=8'h00, ZERO=1.
- DATA1=8'hFF, DATA2=8'h02, SELECT=001 -> RESULT=8'h01, ZERO=0.
REQ-039 ALU logic, forward and reserved operations, each with SELECT as given:
- DATA1=8'hF0, DATA2=8'h3C, SELECT=010 -> RESULT=8'h30.
- Same operands, SELECT=011 -> RESULT=8'hFC.
- Same operands, SELECT=000 -> RESULT=8'h3C.
- Same operands, SELECT=111 -> RESULT=8'h00, ZERO=1.
